// File: rtl/jzjpcc_pkg.sv
// Shared definitions for the JZJ pipelined core front end.
// Holds the canonical NOP encoding, the control-transfer opcodes recognised by
// the decode-stage branch logic, and a helper for the word-address PC width.
package jzjpcc_pkg;

  // addi x0, x0, 0: used to fill squashed decode slots.
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [6:0] {
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111
  } opcode_t;

  // Width of a word-aligned PC spanning bits [pc_max_b:2].
  function automatic int unsigned pc_width(input int unsigned pc_max_b);
    return pc_max_b - 1;
  endfunction

endpackage

// File: rtl/jzjpcc_fetch_unit.sv
// Fetch stage: owns the PC, addresses the synchronous instruction memory and
// presents the fetched word plus its PC to decode. A taken control transfer
// redirects the PC and turns the in-flight sequential word into a NOP bubble;
// a stall freezes all state.
//
// Ports:
//   clock_i                    core clock, rising edge
//   reset_ni                   asynchronous active-low reset
//   stall_i                    hazard hold: freeze PC and decode outputs
//   pc_ct_write_enable_i       take control_transfer_new_pc_i
//   control_transfer_new_pc_i  redirect target (word address)
//   instruction_address_o      word address to instruction memory
//   instruction_data_i         memory data, valid one cycle after address
//   instruction_decode_o       instruction to decode (NOP when squashed)
//   current_pc_decode_o        word address of instruction_decode_o
//   decode_valid_o             1 = real instruction, 0 = bubble
module jzjpcc_fetch_unit
  import jzjpcc_pkg::*;
#(
  parameter int unsigned       PC_MAX_B = 15,
  parameter logic [PC_MAX_B:2] RESET_PC = '0
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              stall_i,
  input  logic              pc_ct_write_enable_i,
  input  logic [PC_MAX_B:2] control_transfer_new_pc_i,
  output logic [PC_MAX_B:2] instruction_address_o,
  input  logic [31:0]       instruction_data_i,
  output logic [31:0]       instruction_decode_o,
  output logic [PC_MAX_B:2] current_pc_decode_o,
  output logic              decode_valid_o
);

  localparam int unsigned       PcWidth = pc_width(PC_MAX_B);
  localparam logic [PC_MAX_B:2] PcOne   = {{(PcWidth - 1){1'b0}}, 1'b1};

  logic [PC_MAX_B:2] pc_fetch_q, pc_fetch_d;
  logic [PC_MAX_B:2] cur_pc_q, cur_pc_d;
  logic              squash_q, squash_d;

  always_comb begin
    pc_fetch_d = pc_fetch_q;
    cur_pc_d   = cur_pc_q;
    squash_d   = squash_q;
    if (stall_i) begin
      // Hold everything; a redirect presented alongside a stall is dropped.
    end else if (pc_ct_write_enable_i) begin
      pc_fetch_d = control_transfer_new_pc_i;
      cur_pc_d   = pc_fetch_q;
      squash_d   = 1'b1;  // kill the sequential word already in flight
    end else begin
      pc_fetch_d = pc_fetch_q + PcOne;  // wraps modulo 2^PcWidth
      cur_pc_d   = pc_fetch_q;
      squash_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_fetch_q <= RESET_PC;
      cur_pc_q   <= RESET_PC;
      squash_q   <= 1'b1;
    end else begin
      pc_fetch_q <= pc_fetch_d;
      cur_pc_q   <= cur_pc_d;
      squash_q   <= squash_d;
    end
  end

  // While stalled, re-read the decode-stage word so memory still holds it
  // when the stall releases.
  assign instruction_address_o = stall_i ? cur_pc_q : pc_fetch_q;
  assign instruction_decode_o  = squash_q ? NOP_INSTRUCTION : instruction_data_i;
  assign current_pc_decode_o   = cur_pc_q;
  assign decode_valid_o        = ~squash_q;

endmodule

// File: tb/tb_jzjpcc_fetch_unit.sv
module tb_jzjpcc_fetch_unit;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 14-bit PC, reset to word 4.
  logic        rst_n, stall, ct_we;
  logic [15:2] ct_pc, addr, cur_pc;
  logic [31:0] idata, idec;
  logic        valid;

  // Small instance for wraparound: 3-bit PC, reset to word 7.
  logic        rst2_n;
  logic [4:2]  addr2, cur_pc2;
  logic [31:0] idata2, idec2;
  logic        valid2;

  logic [31:0] mem [16384];

  int errors = 0;
  int checks = 0;

  // Model state for the randomized run.
  logic [15:2] m_fetch, m_dec;
  logic        m_valid;

  jzjpcc_fetch_unit #(.PC_MAX_B(15), .RESET_PC(14'd4)) dut (
    .clock_i                  (clk),
    .reset_ni                 (rst_n),
    .stall_i                  (stall),
    .pc_ct_write_enable_i     (ct_we),
    .control_transfer_new_pc_i(ct_pc),
    .instruction_address_o    (addr),
    .instruction_data_i       (idata),
    .instruction_decode_o     (idec),
    .current_pc_decode_o      (cur_pc),
    .decode_valid_o           (valid)
  );

  jzjpcc_fetch_unit #(.PC_MAX_B(4), .RESET_PC(3'd7)) dut_wrap (
    .clock_i                  (clk),
    .reset_ni                 (rst2_n),
    .stall_i                  (1'b0),
    .pc_ct_write_enable_i     (1'b0),
    .control_transfer_new_pc_i(3'd0),
    .instruction_address_o    (addr2),
    .instruction_data_i       (idata2),
    .instruction_decode_o     (idec2),
    .current_pc_decode_o      (cur_pc2),
    .decode_valid_o           (valid2)
  );

  // Synchronous instruction memory.
  always @(posedge clk) begin
    idata  <= mem[addr];
    idata2 <= mem[{11'd0, addr2}];
  end

  // Advance one clock: returns 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; ct_we = 1'b0; ct_pc = '0;
    rst_n = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;  // release away from the edge
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16384; i++) mem[i] = i;
    stall = 1'b0; ct_we = 1'b0; ct_pc = '0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (addr !== 14'd4 || cur_pc !== 14'd4 || valid !== 1'b0 || idec !== Nop) begin
      errors++;
      $display("FAIL reset_hold: addr=%h cur=%h valid=%b idec=%h, required 4 4 0 %h",
               addr, cur_pc, valid, idec, Nop);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (addr !== 14'd4 || valid !== 1'b0 || idec !== Nop) begin
      errors++;
      $display("FAIL reset_cycle1: addr=%h valid=%b idec=%h, required 4 0 %h",
               addr, valid, idec, Nop);
    end
    tick();
    checks++;
    if (cur_pc !== 14'd4 || idec !== 32'd4 || valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_cycle2: cur=%h idec=%h valid=%b, required 4 4 1", cur_pc, idec, valid);
    end
  endtask

  // Continues from test_reset: decode at word 4.
  task automatic test_sequential();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (cur_pc !== 14'(4 + k) || idec !== 32'(4 + k) || valid !== 1'b1) begin
        errors++;
        $display("FAIL sequential[%0d]: cur=%h idec=%h valid=%b, required %h %h 1",
                 k, cur_pc, idec, valid, 14'(4 + k), 32'(4 + k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick(); tick();  // edges take pcFetch 4 -> 7
    checks++;
    if (addr !== 14'd7) begin
      errors++;
      $display("FAIL redirect_setup: addr=%h required 7", addr);
    end
    ct_we = 1'b1; ct_pc = 14'h20;
    tick();
    ct_we = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || idec !== Nop || cur_pc !== 14'd7 || addr !== 14'h20) begin
      errors++;
      $display("FAIL redirect_bubble: valid=%b idec=%h cur=%h addr=%h, required 0 %h 7 20",
               valid, idec, cur_pc, addr, Nop);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idec !== 32'h20 || cur_pc !== 14'h20) begin
      errors++;
      $display("FAIL redirect_target: valid=%b idec=%h cur=%h, required 1 20 20",
               valid, idec, cur_pc);
    end
  endtask

  // Continues from test_redirect: decode at 0x20, pcFetch 0x21.
  task automatic test_stall_redirect();
    stall = 1'b1; ct_we = 1'b1; ct_pc = 14'h100;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++;
      if (addr !== 14'h20 || cur_pc !== 14'h20 || valid !== 1'b1 || idec !== 32'h20) begin
        errors++;
        $display("FAIL stall_hold[%0d]: addr=%h cur=%h valid=%b idec=%h, required 20 20 1 20",
                 k, addr, cur_pc, valid, idec);
      end
      tick();
    end
    stall = 1'b0; ct_we = 1'b0;
    tick();
    checks++;
    if (cur_pc !== 14'h21 || valid !== 1'b1 || idec !== 32'h21) begin
      errors++;
      $display("FAIL stall_release: cur=%h valid=%b idec=%h, required 21 1 21",
               cur_pc, valid, idec);
    end
    ct_we = 1'b1;
    tick();
    ct_we = 1'b0;
    checks++;
    if (cur_pc !== 14'h22 || valid !== 1'b0) begin
      errors++;
      $display("FAIL post_stall_redirect: cur=%h valid=%b, required 22 0", cur_pc, valid);
    end
    tick();
    checks++;
    if (cur_pc !== 14'h100 || idec !== 32'h100 || valid !== 1'b1) begin
      errors++;
      $display("FAIL post_stall_target: cur=%h idec=%h valid=%b, required 100 100 1",
               cur_pc, idec, valid);
    end
  endtask

  task automatic test_wrap();
    rst2_n = 1'b0;
    tick();
    #2 rst2_n = 1'b1;
    #1;
    checks++;
    if (addr2 !== 3'd7 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: addr=%h valid=%b, required 7 0", addr2, valid2);
    end
    tick();
    checks++;
    if (cur_pc2 !== 3'd7 || addr2 !== 3'd0 || idec2 !== 32'd7 || valid2 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge1: cur=%h addr=%h idec=%h valid=%b, required 7 0 7 1",
               cur_pc2, addr2, idec2, valid2);
    end
    tick();
    checks++;
    if (cur_pc2 !== 3'd0 || idec2 !== 32'd0 || addr2 !== 3'd1) begin
      errors++;
      $display("FAIL wrap_edge2: cur=%h idec=%h addr=%h, required 0 0 1", cur_pc2, idec2, addr2);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    tick(); tick();
    ct_we = 1'b1; ct_pc = 14'h55;
    tick();
    ct_we = 1'b0;
    #2;  // inside the bubble, well away from any edge
    rst_n = 1'b0;
    #1;
    checks++;
    if (addr !== 14'd4 || cur_pc !== 14'd4 || valid !== 1'b0 || idec !== Nop) begin
      errors++;
      $display("FAIL midrun_reset: addr=%h cur=%h valid=%b idec=%h, required 4 4 0 %h",
               addr, cur_pc, valid, idec, Nop);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_fetch = 14'd4; m_dec = 14'd4; m_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_idec;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    do_reset();
    model_reset();
    #1;
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      ct_we = ($urandom_range(0, 5) == 0);
      ct_pc = 14'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
      #2;
      exp_idec = m_valid ? mem[m_dec] : Nop;
      checks++;
      if (addr !== (stall ? m_dec : m_fetch) || cur_pc !== m_dec || valid !== m_valid ||
          idec !== exp_idec) begin
        errors++;
        $display("FAIL random[%0d]: addr=%h cur=%h valid=%b idec=%h, required %h %h %b %h",
                 c, addr, cur_pc, valid, idec, stall ? m_dec : m_fetch, m_dec, m_valid,
                 exp_idec);
      end
      @(posedge clk);
      if (!stall) begin
        m_dec   = m_fetch;
        m_valid = !ct_we;
        m_fetch = ct_we ? ct_pc : m_fetch + 14'd1;
      end
      #1;
    end
  endtask

  initial begin
    rst2_n = 1'b0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_midrun_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
